// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg: shared state encodings and flash command codes for flash_ctrl
package flash_ctrl_pkg;
  localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;
  typedef enum logic [2:0] {
    IDLE,
    CMD_SETUP,
    CMD_WE,
    CMD_HOLD,
    RD_ADDR,
    RD_WAIT,
    RD_DONE
  } state_t;
endpackage

// File: rtl/flash_rr_arb.sv
// flash_rr_arb: two-way round-robin arbiter
//   clk, rst (sync, active-low) | req0, req1 requests | adv: commit current grant
//   gnt[1:0]: one-hot grant (combinational), ties go to the port not granted last
module flash_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic last;
  always_comb begin
    gnt[0] = req0 & (~req1 | last);
    gnt[1] = req1 & (~req0 | ~last);
  end
  always_ff @(posedge clk)
    if (!rst) last <= 1'b1;
    else if (adv && (req0 || req1)) last <= gnt[1];
endmodule

// File: rtl/flash_ctrl.sv
// flash_ctrl: two-port read controller for a 16-bit parallel NOR flash
//   clk, rst (sync, active-low)
//   req0/addr0/ack0 boot port, req1/addr1/ack1 data port, rdata valid with ack, busy
//   flash_*: device address, split data bus and active-low strobes
module flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int WE_PULSE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [22:1] addr0,
  input  logic [22:1] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [22:1] flash_addr,
  output logic [15:0] flash_data_o,
  output logic        flash_data_oe,
  input  logic [15:0] flash_data_i,
  output logic        flash_ce_n,
  output logic        flash_we_n,
  output logic        flash_oe_n,
  output logic        flash_rp_n,
  output logic        flash_byte_n,
  output logic        flash_vpen
);
  state_t      state, state_n;
  logic [1:0]  gnt;
  logic [1:0]  ack_q;
  logic [3:0]  cnt;
  logic        cnt_last;
  logic        array_mode;
  logic        gid;
  logic        cmd;
  logic        rd;
  flash_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .adv  (state == IDLE),
    .gnt  (gnt)
  );
  assign cnt_last = cnt == 4'd1;
  // One counter times both the WE pulse and the read wait; the phases never overlap.
  always_ff @(posedge clk)
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      array_mode <= 1'b0;
      flash_addr <= '0;
      gid        <= 1'b0;
      rdata      <= '0;
      ack_q      <= '0;
    end else begin
      state <= state_n;
      ack_q <= '0;
      if (state == IDLE && gnt != 2'b00) begin
        flash_addr <= gnt[1] ? addr1 : addr0;
        gid        <= gnt[1];
      end
      if (state == CMD_SETUP) cnt <= 4'(WE_PULSE);
      else if (state == RD_ADDR) cnt <= 4'(WAIT_CYCLES);
      else if (state == CMD_WE || state == RD_WAIT) cnt <= cnt - 4'd1;
      if (state == CMD_HOLD) array_mode <= 1'b1;
      // Capture on the edge leaving the last wait cycle so data and ack are both valid in RD_DONE.
      if (state == RD_WAIT && cnt_last) begin
        rdata <= flash_data_i;
        ack_q <= gid ? 2'b10 : 2'b01;
      end
    end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = gnt != 2'b00 ? (array_mode ? RD_ADDR : CMD_SETUP) : IDLE;
      CMD_SETUP: state_n = CMD_WE;
      CMD_WE:    state_n = cnt_last ? CMD_HOLD : CMD_WE;
      CMD_HOLD:  state_n = RD_ADDR;
      RD_ADDR:   state_n = RD_WAIT;
      RD_WAIT:   state_n = cnt_last ? RD_DONE : RD_WAIT;
      RD_DONE:   state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    cmd           = state inside {CMD_SETUP, CMD_WE, CMD_HOLD};
    rd            = state inside {RD_ADDR, RD_WAIT, RD_DONE};
    flash_ce_n    = ~(cmd | rd);
    flash_we_n    = state != CMD_WE;
    flash_oe_n    = ~rd;
    flash_data_oe = cmd;
    flash_data_o  = cmd ? FLASH_CMD_READ_ARRAY : 16'h0000;
  end
  assign ack0         = ack_q[0];
  assign ack1         = ack_q[1];
  assign busy         = state != IDLE;
  assign flash_rp_n   = 1'b1;
  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b1;
endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: directed self-checking bench for flash_ctrl
module tb_flash_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [22:1] addr0, addr1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata;
  logic [22:1] flash_addr;
  logic [15:0] flash_data_o, flash_data_i;
  logic        flash_data_oe, flash_ce_n, flash_we_n, flash_oe_n;
  logic        flash_rp_n, flash_byte_n, flash_vpen;
  int          checks = 0;
  int          errors = 0;
  int          who, n, wel, bad;
  logic [22:1] ra;
  flash_ctrl dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .flash_addr(flash_addr),
    .flash_data_o(flash_data_o), .flash_data_oe(flash_data_oe), .flash_data_i(flash_data_i),
    .flash_ce_n(flash_ce_n), .flash_we_n(flash_we_n), .flash_oe_n(flash_oe_n),
    .flash_rp_n(flash_rp_n), .flash_byte_n(flash_byte_n), .flash_vpen(flash_vpen)
  );
  always #5 clk = ~clk;
  assign flash_data_i = (!flash_oe_n && !flash_ce_n)
                      ? ((flash_addr == 22'h000010) ? 16'hA5A5 : (flash_addr[16:1] ^ 16'h1234))
                      : 16'hDEAD;
  always @(negedge clk) begin
    checks++;
    assert (!(flash_data_oe && !flash_oe_n) && !(ack0 && ack1))
    else begin
      errors++;
      $error("FAIL bus_excl: oe=%b oe_n=%b ack0=%b ack1=%b", flash_data_oe, flash_oe_n, ack0, ack1);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_ack(output int w, output int cyc, output int we_low, output int bad_d,
                          output logic [22:1] rd_addr);
    w = -1; cyc = 0; we_low = 0; bad_d = 0; rd_addr = '0;
    for (int i = 0; i < 60 && w < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (!flash_we_n) we_low++;
      if (flash_data_oe && flash_data_o !== 16'h00FF) bad_d++;
      if (!flash_oe_n) rd_addr = flash_addr;
      if (ack0) w = 0;
      else if (ack1) w = 1;
    end
  endtask
  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {flash_ce_n, flash_we_n, flash_oe_n, flash_data_oe, ack0, ack1, busy}, 7'b1110000);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_addr", {flash_addr, flash_data_o}, 38'h0);
    check("const_pins", {flash_rp_n, flash_byte_n, flash_vpen}, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    req0 = 1'b1; addr0 = 22'h000010;
    wait_ack(who, n, wel, bad, ra);
    req0 = 1'b0;
    check("cold_who", who, 0);
    check("cold_lat", n, 9);
    check("cold_we_low", wel, 2);
    check("cold_cmd_data", bad, 0);
    check("cold_addr", ra, 22'h000010);
    check("cold_rdata", rdata, 16'hA5A5);
    @(negedge clk);
    check("after_done", {flash_ce_n, flash_oe_n, busy, ack0}, 4'b1100);
    check("rdata_hold", rdata, 16'hA5A5);
    req1 = 1'b1; addr1 = 22'h1FFFFF;
    wait_ack(who, n, wel, bad, ra);
    req1 = 1'b0;
    check("warm_who", who, 1);
    check("warm_lat", n, 5);
    check("warm_we_low", wel, 0);
    check("warm_addr", ra, 22'h1FFFFF);
    check("warm_rdata", rdata, 16'hEDCB);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      req0 = 1'b1; addr0 = 22'h000020; req1 = 1'b1; addr1 = 22'h000030;
      wait_ack(who, n, wel, bad, ra);
      req0 = 1'b0;
      check("tie_first", who, 0);
      check("tie_first_rdata", rdata, 16'h1214);
      wait_ack(who, n, wel, bad, ra);
      req1 = 1'b0;
      check("tie_second", who, 1);
      check("tie_second_lat", n, 6);
      check("tie_second_rdata", rdata, 16'h1204);
    end
    @(negedge clk);
    req1 = 1'b1; addr1 = 22'h000040;
    repeat (2) @(negedge clk);
    req0 = 1'b1; addr0 = 22'h000050;
    wait_ack(who, n, wel, bad, ra);
    check("rr_first", who, 1);
    check("rr_first_lat", n, 3);
    check("rr_first_rdata", rdata, 16'h1274);
    wait_ack(who, n, wel, bad, ra);
    req0 = 1'b0;
    check("rr_second", who, 0);
    check("rr_second_rdata", rdata, 16'h1264);
    wait_ack(who, n, wel, bad, ra);
    req1 = 1'b0;
    check("rr_third", who, 1);
    check("rr_third_lat", n, 6);
    check("rr_third_rdata", rdata, 16'h1274);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; addr0 = 22'h000010;
    repeat (2) @(negedge clk);
    check("abort_in_we", {flash_we_n, flash_data_oe, ack0}, 3'b010);
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("abort_idle", {flash_ce_n, flash_we_n, flash_oe_n, flash_data_oe, ack0, ack1, busy}, 7'b1110000);
    check("abort_rdata", rdata, 16'h0000);
    rst = 1'b1;
    req0 = 1'b1;
    wait_ack(who, n, wel, bad, ra);
    req0 = 1'b0;
    check("reissue_who", who, 0);
    check("reissue_lat", n, 9);
    check("reissue_we_low", wel, 2);
    check("reissue_rdata", rdata, 16'hA5A5);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
